bsg_host_req_credit_fifo: RTL

//  Credit-limited request buffer between the host DPI endpoint and the manycore io link.

---
 rtl/bsg_host_req_credit_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bsg_host_req_credit_fifo.sv
// bsg_host_req_credit_fifo
//   Credit-limited request buffer between the host DPI endpoint and the manycore
//   io link. Requests are held until tag programming completes, then released
//   while fewer than max_credits_p requests are outstanding. A level drain
//   request stops intake and reports fence_done_o once everything has been sent
//   and every credit has come back.
//   Optional feature: define BSG_HOST_REQ_STATS_EN to add the saturating
//   sent_cnt_o / stall_cnt_o statistics counters (and the stat_width_p parameter).
module bsg_host_req_credit_fifo #(
  parameter int width_p       = 128,
  parameter int els_p         = 4,
  parameter int max_credits_p = 16
`ifdef BSG_HOST_REQ_STATS_EN
  , parameter int stat_width_p = 32
`endif
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 reset_done_i,
  input  logic                                 req_v_i,
  input  logic [width_p-1:0]                   req_data_i,
  output logic                                 req_ready_o,
  output logic                                 req_v_o,
  output logic [width_p-1:0]                   req_data_o,
  input  logic                                 req_yumi_i,
  input  logic                                 credit_v_i,
  input  logic                                 drain_i,
  output logic                                 fence_done_o,
  output logic [$clog2(max_credits_p+1)-1:0]   credits_used_o,
  output logic                                 err_o
`ifdef BSG_HOST_REQ_STATS_EN
  , output logic [stat_width_p-1:0]            sent_cnt_o
  , output logic [stat_width_p-1:0]            stall_cnt_o
`endif
);

  localparam int idx_w  = $clog2(els_p);
  localparam int ptr_w  = idx_w + 1;
  localparam int cred_w = $clog2(max_credits_p + 1);
  localparam logic [cred_w-1:0] max_cred = cred_w'(max_credits_p);

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_r;
  logic [ptr_w-1:0]   wptr_r;
  logic [ptr_w-1:0]   rptr_r;
  logic [cred_w-1:0]  credits_r;
  logic               err_r;
  logic [width_p-1:0] mem_r [els_p];

  logic empty;
  logic full;
  logic credits_avail;
  logic enq;
  logic deq;
  logic yumi_err;
  logic credit_err;

  // Wrap bit distinguishes full from empty when the indices coincide.
  assign empty         = (wptr_r == rptr_r);
  assign full          = (wptr_r[ptr_w-1] != rptr_r[ptr_w-1]) &&
                         (wptr_r[idx_w-1:0] == rptr_r[idx_w-1:0]);
  assign credits_avail = (credits_r < max_cred);

  assign req_ready_o  = (state_r == RUN) & ~full;
  assign req_v_o      = ~empty & credits_avail & (state_r != WAIT);
  assign req_data_o   = mem_r[rptr_r[idx_w-1:0]];
  assign fence_done_o = (state_r == DRAIN) & empty & (credits_r == '0);

  assign enq        = req_v_i & req_ready_o;
  assign deq        = req_yumi_i & req_v_o;
  // Illegal events are flagged and otherwise ignored.
  assign yumi_err   = req_yumi_i & ~req_v_o;
  assign credit_err = credit_v_i & (credits_r == '0) & ~deq;

  assign credits_used_o = credits_r;
  assign err_o          = err_r;

  // Packet storage; no reset, contents only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[idx_w-1:0]] <= req_data_i;
  end

  // Control: FSM, pointers, credit counter and sticky error flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= WAIT;
      wptr_r    <= '0;
      rptr_r    <= '0;
      credits_r <= '0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        WAIT:    if (reset_done_i) state_r <= RUN;
        RUN:     if (drain_i)      state_r <= DRAIN;
        DRAIN:   if (!drain_i)     state_r <= RUN;
        default: state_r <= WAIT;
      endcase

      if (enq) wptr_r <= wptr_r + ptr_w'(1);
      if (deq) rptr_r <= rptr_r + ptr_w'(1);

      // A send and a returned credit in the same cycle cancel out.
      if (deq && !credit_v_i)
        credits_r <= credits_r + cred_w'(1);
      else if (!deq && credit_v_i && (credits_r != '0))
        credits_r <= credits_r - cred_w'(1);

      if (yumi_err || credit_err) err_r <= 1'b1;
    end
  end

`ifdef BSG_HOST_REQ_STATS_EN
  logic [stat_width_p-1:0] sent_cnt_r;
  logic [stat_width_p-1:0] stall_cnt_r;
  logic                    stall;

  function automatic logic [stat_width_p-1:0] sat_inc(input logic [stat_width_p-1:0] v);
    return (&v) ? v : v + stat_width_p'(1);
  endfunction

  assign stall       = ~empty & (credits_r == max_cred);
  assign sent_cnt_o  = sent_cnt_r;
  assign stall_cnt_o = stall_cnt_r;

  // Saturating statistics: packets sent and cycles stalled on credits.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sent_cnt_r  <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (deq)   sent_cnt_r  <= sat_inc(sent_cnt_r);
      if (stall) stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end
`endif

endmodule
